// File: rtl/apb_slave_regbank.sv
// APB3 completer holding DEPTH x 32-bit registers, with registered outputs and error flagging.
// Define APB_SLV_WAIT_EN to compile in the WAIT_CYC wait-state counter; otherwise every transfer is zero-wait.
module apb_slave_regbank #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned WAIT_CYC = 0,
    parameter logic [31:0] RST_VAL  = 32'h0
) (
    input  logic        Pclk,
    input  logic        Preset,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr
);
    localparam int unsigned AW = $clog2(DEPTH);
`ifdef APB_SLV_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif
    localparam int unsigned EFF_WAIT   = WAIT_EN ? WAIT_CYC : 0;
    localparam logic [31:0] BANK_BYTES = 32'(DEPTH * 4);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          pready_q, pready_d;
    logic          pslverr_q, pslverr_d;
    logic [31:0]   prdata_q, prdata_d;
    logic [31:0]   mem_q [DEPTH];
    logic          mem_we;
`ifdef APB_SLV_WAIT_EN
    logic [3:0]    cnt_q, cnt_d;
`endif

    logic [AW-1:0] in_idx;
    logic          in_err;
    logic          ld, ld_write, ld_err;
    logic [AW-1:0] ld_idx;

    assign in_idx = Paddr[AW+1:2];
    assign in_err = (Paddr >= BANK_BYTES) || (Paddr[1:0] != 2'b00);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        mem_we    = 1'b0;
        ld        = 1'b0;
        ld_write  = write_q;
        ld_err    = err_q;
        ld_idx    = idx_q;
`ifdef APB_SLV_WAIT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (Psel && !Penable) begin
                    state_d  = ACCESS;
                    idx_d    = in_idx;
                    write_d  = Pwrite;
                    wdata_d  = Pwdata;
                    err_d    = in_err;
`ifdef APB_SLV_WAIT_EN
                    cnt_d    = 4'(EFF_WAIT);
`endif
                    pready_d = (EFF_WAIT == 0);
                    // Zero-wait transfers complete the response from the live bus values.
                    ld       = (EFF_WAIT == 0);
                    ld_write = Pwrite;
                    ld_err   = in_err;
                    ld_idx   = in_idx;
                end
            end
            ACCESS: begin
                if (!Psel) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else if (Penable) begin
                    if (pready_q) begin
                        mem_we    = write_q && !err_q;
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                    end
`ifdef APB_SLV_WAIT_EN
                    else begin
                        cnt_d = cnt_q - 4'd1;
                        ld    = (cnt_q == 4'd1);
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (ld) begin
            pready_d = 1'b1;
            if (ld_write) begin
                pslverr_d = ld_err;
            end else if (ld_err) begin
                prdata_d  = '0;
                pslverr_d = 1'b1;
            end else begin
                prdata_d  = mem_q[ld_idx];
                pslverr_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= '0;
`endif
            // NOTE: the bank is reset because every register must read back RST_VAL after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= cnt_d;
`endif
            if (mem_we) begin
                mem_q[idx_q] <= wdata_q;
            end
        end
    end

    assign Prdata  = prdata_q;
    assign Pready  = pready_q;
    assign Pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_slave_regbank.sv
// Self-checking bench for apb_slave_regbank: a zero-wait and a WAIT_CYC=3 instance against an array model.
// Expected wait states follow APB_SLV_WAIT_EN, matching the build of the design.
module tb_apb_slave_regbank;
    localparam int          DEPTH   = 16;
    localparam logic [31:0] RST_VAL = 32'hA5A5_5A5A;
`ifdef APB_SLV_WAIT_EN
    localparam int EXP_W3 = 3;
`else
    localparam int EXP_W3 = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        psel0, psel3, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem    [2][DEPTH];
    logic [31:0] ref_prdata [2];

    always #5 clk = ~clk;

    apb_slave_regbank #(.DEPTH(DEPTH), .WAIT_CYC(0), .RST_VAL(RST_VAL)) dut0 (
        .Pclk(clk), .Preset(rst), .Psel(psel0), .Penable(penable), .Pwrite(pwrite),
        .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata0), .Pready(pready0), .Pslverr(pslverr0)
    );

    apb_slave_regbank #(.DEPTH(DEPTH), .WAIT_CYC(3), .RST_VAL(RST_VAL)) dut3 (
        .Pclk(clk), .Preset(rst), .Psel(psel3), .Penable(penable), .Pwrite(pwrite),
        .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata3), .Pready(pready3), .Pslverr(pslverr3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d != 0) ? pready3 : pready0;
    endfunction

    function automatic logic slverr(input int d);
        return (d != 0) ? pslverr3 : pslverr0;
    endfunction

    function automatic logic [31:0] rdata_of(input int d);
        return (d != 0) ? prdata3 : prdata0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[d][i] = RST_VAL;
            ref_prdata[d] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transfer; bus values are scrambled after setup to prove they were captured.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit idle_after, output logic [31:0] rdata);
        int          cyc, low_cnt, exp_wait, idx;
        bit          err;
        logic [31:0] exp_rd;
        string       tag;
        exp_wait = (d != 0) ? EXP_W3 : 0;
        err      = (addr >= 32'(DEPTH * 4)) || (addr % 4 != 0);
        idx      = int'((addr / 4) % DEPTH);
        tag      = $sformatf("dut%0d %s @%h", (d != 0) ? 3 : 0, wr ? "wr" : "rd", addr);

        psel0 = (d == 0); psel3 = (d != 0);
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        tick();
        cyc = 1;
        penable = 1'b1;
        paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom);
        low_cnt = 0;
        while (!rdy(d) && cyc < 40) begin
            low_cnt++;
            tick();
            cyc++;
        end
        check({tag, " wait_cycles"}, 32'(low_cnt), 32'(exp_wait));

        if (wr) begin
            exp_rd = ref_prdata[d];
            if (!err) ref_mem[d][idx] = wdata;
        end else begin
            exp_rd = err ? 32'h0 : ref_mem[d][idx];
        end
        ref_prdata[d] = exp_rd;
        check({tag, " prdata"}, rdata_of(d), exp_rd);
        check({tag, " pslverr"}, 32'(slverr(d)), 32'(err));
        rdata = rdata_of(d);

        tick();
        cyc++;
        check({tag, " latency"}, 32'(cyc), 32'(2 + exp_wait));
        check({tag, " pready_drop"}, 32'(rdy(d)), 32'h0);
        penable = 1'b0;
        if (idle_after) begin
            psel0 = 1'b0; psel3 = 1'b0;
            tick();
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        wr;
        logic [31:0] addr;
        int          d, r;

        rst = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();
        check("reset pready0", 32'(pready0), 32'h0);
        check("reset pslverr0", 32'(pslverr0), 32'h0);
        check("reset prdata0", prdata0, 32'h0);
        check("reset pready3", 32'(pready3), 32'h0);

        xfer(0, 1'b0, 32'h4, 32'h0, 1'b1, rd);
        check("first read 0x4", rd, RST_VAL);
        xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b1, rd);
        xfer(0, 1'b0, 32'h8, 32'h0, 1'b1, rd);
        check("readback 0x8", rd, 32'hDEAD_BEEF);

        // Reset in the middle of a read whose response is already on the bus.
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8;
        tick();
        penable = 1'b1;
        @(negedge clk) rst = 1'b1;
        #1;
        check("midreset pready0", 32'(pready0), 32'h0);
        check("midreset pslverr0", 32'(pslverr0), 32'h0);
        check("midreset prdata0", prdata0, 32'h0);
        psel0 = 1'b0; penable = 1'b0;
        model_reset();
        @(negedge clk) rst = 1'b0;
        tick();
        xfer(0, 1'b0, 32'h4, 32'h0, 1'b1, rd);
        check("post-reset read 0x4", rd, RST_VAL);
        xfer(0, 1'b0, 32'h8, 32'h0, 1'b1, rd);
        check("post-reset read 0x8", rd, RST_VAL);

        xfer(1, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b1, rd);
        xfer(1, 1'b0, 32'h8, 32'h0, 1'b1, rd);
        check("dut3 readback 0x8", rd, 32'hDEAD_BEEF);

        xfer(0, 1'b0, 32'h40, 32'h0, 1'b1, rd);
        check("oob read data", rd, 32'h0);
        xfer(0, 1'b1, 32'h42, 32'h1234, 1'b1, rd);
        xfer(0, 1'b0, 32'h0, 32'h0, 1'b1, rd);
        check("bad write left reg0", rd, RST_VAL);
        xfer(0, 1'b0, 32'h3C, 32'h0, 1'b1, rd);
        xfer(0, 1'b0, 32'h41, 32'h0, 1'b1, rd);
        xfer(1, 1'b1, 32'h7E, 32'h55, 1'b1, rd);

        for (int k = 0; k < 2; k++) begin
            xfer(k, 1'b1, 32'h0, 32'h1, 1'b0, rd);
            xfer(k, 1'b1, 32'h4, 32'h2, 1'b0, rd);
            xfer(k, 1'b0, 32'h0, 32'h0, 1'b0, rd);
            check("b2b read 0x0", rd, 32'h1);
            xfer(k, 1'b0, 32'h4, 32'h0, 1'b1, rd);
            check("b2b read 0x4", rd, 32'h2);
        end

        // Abort a write to 0xC on the wait-state instance by dropping Psel.
        xfer(1, 1'b1, 32'hC, 32'h0000_0C0C, 1'b1, rd);
        psel0 = 1'b0; psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hFFFF_FFFF;
        tick();
        penable = 1'b1;
        repeat ((EXP_W3 > 1) ? 1 : 0) begin
            tick();
            check("abort wait pready", 32'(pready3), 32'h0);
        end
        psel3 = 1'b0; penable = 1'b0;
        tick();
        check("abort pready", 32'(pready3), 32'h0);
        check("abort pslverr", 32'(pslverr3), 32'h0);
        tick();
        check("abort stays idle", 32'(pready3), 32'h0);
        xfer(1, 1'b0, 32'hC, 32'h0, 1'b1, rd);
        check("abort left 0xC", rd, 32'h0000_0C0C);

        for (int n = 0; n < 60; n++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom);
            r  = int'($urandom_range(0, 9));
            if (r < 8)       addr = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (r == 8) addr = 32'($urandom_range(DEPTH, 4 * DEPTH) * 4);
            else             addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            xfer(d, wr, addr, $urandom, 1'($urandom), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
